// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// One operand bit per cycle: 32 CALC cycles, then one FIX cycle for sign correction.
module muldiv_unit #(
  parameter logic [31:0] ZERO_DIV_LO = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;
  logic [31:0] r_a_raw;
  logic [31:0] r_opb;
  logic [63:0] r_acc;
  logic [32:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_msum;
  logic [32:0] w_dshift;
  logic [33:0] w_ddiff;
  logic        w_dge;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_remf;

  // Magnitudes only for signed ops; |0x80000000| stays 0x80000000 as unsigned.
  assign w_abs_a = (~op[0] & a[31]) ? (~a + 32'd1) : a;
  assign w_abs_b = (~op[0] & b[31]) ? (~b + 32'd1) : b;

  // Multiply: r_acc holds {partial product, remaining multiplier bits}.
  assign w_msum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opb : 32'd0)};

  // Divide: r_acc[31:0] shifts dividend bits out and quotient bits in.
  assign w_dshift = {r_rem[31:0], r_acc[31]};
  assign w_ddiff  = {1'b0, w_dshift} - {2'b00, r_opb};
  assign w_dge    = ~w_ddiff[33];

  assign w_prod   = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quot   = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_remf   = r_neg_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == 5'd0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_a_raw  <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_neg_q  <= ~op[0] & (a[31] ^ b[31]);
            r_neg_r  <= ~op[0] & a[31];
            r_dz     <= op[1] & (b == 32'd0);
            r_a_raw  <= a;
            r_opb    <= op[1] ? w_abs_b : w_abs_a;
            r_acc    <= {32'd0, (op[1] ? w_abs_a : w_abs_b)};
            r_rem    <= '0;
            r_cnt    <= 5'd31;
          end else begin
            if (mthi) r_hi <= a;
            if (mtlo) r_lo <= a;
          end
        end
        S_CALC: begin
          if (r_is_div) begin
            r_rem        <= w_dge ? w_ddiff[32:0] : w_dshift;
            r_acc[31:0]  <= {r_acc[30:0], w_dge};
          end else begin
            r_acc <= {w_msum, r_acc[31:1]};
          end
          r_cnt <= r_cnt - 5'd1;
        end
        S_FIX: begin
          if (r_dz) begin
            r_lo <= ZERO_DIV_LO;
            r_hi <= r_a_raw;
          end else if (r_is_div) begin
            r_lo <= w_quot;
            r_hi <= w_remf;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file read ports: consumes rd1/rd2 as operands and executes mult, multu, div, divu, mthi and mtlo.
- HI/LO feed the writeback mux for mfhi/mflo.
- The controller stalls on busy.

Parameters:
- ZERO_DIV_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero.

Ports:
- clk      input   1   system clock; rising-edge.
- reset    input   1   asynchronous, active-low; 0 clears all state immediately.
- start    input   1   begin operation selected by op; sampled only in IDLE.
- op       input   2   00 mult, 01 multu, 10 div, 11 divu.
- a        input   32  operand rs (rd1); dividend for div/divu.
- b        input   32  operand rt (rd2); divisor for div/divu.
- mthi     input   1   write a into HI; IDLE only.
- mtlo     input   1   write a into LO; IDLE only.
- busy     output  1   operation in progress; controller stalls mfhi/mflo/new muldiv.
- done     output  1   one-cycle pulse; HI/LO just updated by a completed operation.
- hi       output  32  HI register.
- lo       output  32  LO register.

Behaviour:
- Reset (reset==0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. An in-flight operation is abandoned with no HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - latch |a| and |b|; absolute values only for signed ops (op[0]==0).
  - latch result-sign flags: quotient/product negative = a[31]^b[31]; remainder negative = a[31].
  - latch div-by-zero flag (b==0, div ops only).
  - counter=31; state=CALC; busy=1.
- IDLE, start=0: mthi -> hi<=a; mtlo -> lo<=a; both may assert together.
- start and mthi/mtlo in the same cycle: start wins, mthi/mtlo ignored.
- CALC, 32 edges (E1..E32), one bit per edge:
  - multiply: shift-add into 64-bit accumulator.
  - divide: restoring shift-subtract, 33-bit partial remainder.
  - counter decrements; at counter==0 -> FIX.
- FIX, edge E33:
  - apply two's-complement negation per sign flags; 64-bit for product, separately for quotient and remainder.
  - mult/multu: hi=product[63:32], lo=product[31:0].
  - div/divu: lo=quotient, hi=remainder.
  - div-by-zero (signed or unsigned): lo=ZERO_DIV_LO, hi=a as latched at E0 (raw, unsigned-magnitude not used).
  - done=1 for the cycle after E33; busy=0; state=IDLE.
- Latency: HI/LO valid after the 33rd rising edge following the start edge; busy high exactly 33 cycles.
- start, mthi, mtlo while busy: ignored; no queuing.
- op, a, b: may change after E0 without effect.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no trap).
- |0x80000000| handled as unsigned 0x80000000; internal magnitude is 32-bit unsigned.
- done: deasserts on the next edge. A new start is accepted in the same cycle done is high (state already IDLE).
- No exceptions raised. hi/lo driven directly from registers; no combinational path from inputs.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges: hi=0xFFFFFFFE, lo=0x00000001; done pulses once; busy high 33 cycles.
- mult a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064. div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start divu 10/3; pulse start with mult 5*5 at cycle 10 and mthi a=0x1234 at cycle 12 -> both ignored; final lo=3, hi=1; single done.
- mthi a=0xAAAA5555 with mtlo a=0x0F0F0F0F one cycle later -> hi=0xAAAA5555, lo=0x0F0F0F0F, done stays 0. Same cycle start=1 + mthi=1 -> HI unchanged until op completes.
- reset low mid-CALC (cycle 15, asynchronously between edges) -> busy, done, hi, lo read 0 immediately. After release, multu 6*7 -> lo=42, hi=0 at normal latency.
